// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default geometry, default almost-full
// threshold and a width-generic binary-to-Gray helper.
package fifo_pkg;

    localparam int ADDRSIZE_DEF  = 4;
    localparam int DEPTH_DEF     = 2 ** ADDRSIZE_DEF;
    localparam int AFULL_RST_DEF = 12;

    // Wide enough for the largest legal pointer (ADDRSIZE = 12 -> 13 bits);
    // callers zero-extend on the way in and truncate on the way out.
    localparam int GRAY_MAX_W = 16;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter; each binary bit is the XOR of all
// Gray bits at or above it. Shared by the write and read pointer blocks.
module gray2bin #(
    parameter int N = 5
) (
    input  logic [N-1:0] gray,
    output logic [N-1:0] bin
);

    // A reduction over the upper slice avoids a self-referencing ripple chain.
    for (genvar i = 0; i < N; i++) begin : g_bit
        assign bin[i] = ^gray[N-1:i];
    end

endmodule

// File: rtl/wptr_full_lvl.sv
// Write-domain pointer/status block for the async FIFO: binary and Gray write
// pointers, full flag, fill level, programmable almost-full and sticky overflow.
module wptr_full_lvl
    import fifo_pkg::*;
#(
    parameter int ADDRSIZE  = ADDRSIZE_DEF,
    parameter int AFULL_RST = AFULL_RST_DEF
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    input  logic [ADDRSIZE:0]   wafull_thr,
    input  logic                wovf_clr,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam int W = ADDRSIZE + 1;

    logic [W-1:0] wbin_q, wbin_d;
    logic [W-1:0] wptr_q, wptr_d;
    logic [W-1:0] wlevel_q, wlevel_d;
    logic         wfull_q, wfull_d;
    logic         wafull_q, wafull_d;
    logic         wovf_q, wovf_d;
    logic [W-1:0] rbin;
    logic         wen;
    logic [31:0]  thr;

    gray2bin #(.N(W)) u_rptr_g2b (
        .gray (wq2_rptr),
        .bin  (rbin)
    );

    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    always_comb begin
        wen    = winc & ~wfull_q;
        wbin_d = wbin_q + {{ADDRSIZE{1'b0}}, wen};
        wptr_d = W'(bin2gray(GRAY_MAX_W'(wbin_d)));

        // Full when the write pointer is one whole lap ahead of the read pointer.
        wfull_d  = (wptr_d == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});
        wlevel_d = wbin_d - rbin;

        thr      = (wafull_thr == '0) ? 32'(AFULL_RST) : 32'(wafull_thr);
        wafull_d = ({{(32-W){1'b0}}, wlevel_d} >= thr);

        // Set has priority so a rejected write is never lost to a same-cycle clear.
        if (winc && wfull_q) begin
            wovf_d = 1'b1;
        end else if (wovf_clr) begin
            wovf_d = 1'b0;
        end else begin
            wovf_d = wovf_q;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge wclk) begin
        if (!wrst_n) begin
            wbin_q   <= '0;
            wptr_q   <= '0;
            wlevel_q <= '0;
            wfull_q  <= 1'b0;
            wafull_q <= 1'b0;
            wovf_q   <= 1'b0;
        end else begin
            wbin_q   <= wbin_d;
            wptr_q   <= wptr_d;
            wlevel_q <= wlevel_d;
            wfull_q  <= wfull_d;
            wafull_q <= wafull_d;
            wovf_q   <= wovf_d;
        end
    end

    assign waddr        = wbin_q[ADDRSIZE-1:0];
    assign wptr         = wptr_q;
    assign wfull        = wfull_q;
    assign walmost_full = wafull_q;
    assign wlevel       = wlevel_q;
    assign woverflow    = wovf_q;

endmodule

// File: tb/tb_wptr_full_lvl.sv
// Self-checking bench for wptr_full_lvl: directed steps plus a random phase,
// compared against a word-count model of the FIFO occupancy.
module tb_wptr_full_lvl;

    localparam int ADDRSIZE  = 4;
    localparam int AFULL_RST = 12;
    localparam int DEPTH     = 2 ** ADDRSIZE;
    localparam int W         = ADDRSIZE + 1;

    logic                wclk = 1'b0;
    logic                wrst_n;
    logic                winc;
    logic [W-1:0]        wq2_rptr;
    logic [W-1:0]        wafull_thr;
    logic                wovf_clr;
    logic [ADDRSIZE-1:0] waddr;
    logic [W-1:0]        wptr;
    logic                wfull;
    logic                walmost_full;
    logic [W-1:0]        wlevel;
    logic                woverflow;

    wptr_full_lvl #(.ADDRSIZE(ADDRSIZE), .AFULL_RST(AFULL_RST)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .wq2_rptr     (wq2_rptr),
        .wafull_thr   (wafull_thr),
        .wovf_clr     (wovf_clr),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    always #5 wclk = ~wclk;

    // Model: total words accepted and total words the read side has consumed.
    int m_wr, m_rd, m_level;
    bit m_full, m_afull, m_ovf;
    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [W-1:0] to_gray(input int n);
        logic [W-1:0] b;
        b = W'(n % (2 * DEPTH));
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".waddr"},  32'(waddr),        32'(m_wr % DEPTH));
        check({tag, ".wptr"},   32'(wptr),         32'(to_gray(m_wr)));
        check({tag, ".wfull"},  32'(wfull),        32'(m_full));
        check({tag, ".afull"},  32'(walmost_full), 32'(m_afull));
        check({tag, ".wlevel"}, 32'(wlevel),       32'(m_level));
        check({tag, ".ovf"},    32'(woverflow),    32'(m_ovf));
    endtask

    // One clock edge: present the read pointer, advance the model on the edge,
    // then settle before anything samples the outputs.
    task automatic tick();
        int thr;
        wq2_rptr = to_gray(m_rd);
        @(posedge wclk);
        if (!wrst_n) begin
            m_wr = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        end else begin
            if (winc && m_full) m_ovf = 1;
            else if (wovf_clr)  m_ovf = 0;
            if (winc && !m_full) m_wr++;
            m_level = m_wr - m_rd;
            m_full  = (m_level == DEPTH);
            thr     = (wafull_thr == 0) ? AFULL_RST : int'(wafull_thr);
            m_afull = (m_level >= thr);
        end
        #1;
    endtask

    initial begin
        m_wr = 0; m_rd = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0;
        wrst_n = 1'b0; winc = 1'b1; wafull_thr = '0; wovf_clr = 1'b0;
        wq2_rptr = '0;

        // Reset dominates a pending write request.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_model("reset");
        end
        check("reset_waddr", 32'(waddr), 0);
        wrst_n = 1'b1; winc = 1'b0;
        check("release_waddr", 32'(waddr), 0);
        winc = 1'b1;
        tick();
        check("first_write_waddr", 32'(waddr), 1);
        check_model("first_write");

        // Fill from empty with the read pointer parked at zero.
        wrst_n = 1'b0; winc = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        wrst_n = 1'b1; winc = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            tick();
            check_model("fill");
            check("fill_level", 32'(wlevel), 32'(i));
            check("fill_afull", 32'(walmost_full), 32'(i >= AFULL_RST));
        end
        check("full_gray", 32'(wptr), 32'b11000);
        check("full_flag", 32'(wfull), 1);
        tick();
        check_model("overflow");
        check("overflow_set", 32'(woverflow), 1);
        check("overflow_waddr", 32'(waddr), 0);

        // Set beats clear; a clear alone then drops the flag.
        wovf_clr = 1'b1;
        tick();
        check("ovf_set_wins", 32'(woverflow), 1);
        winc = 1'b0;
        tick();
        check("ovf_cleared", 32'(woverflow), 0);
        check_model("ovf_clear");
        wovf_clr = 1'b0;

        // Drain to three words, then write 40 with the reader trailing by three.
        while (m_level > 3) begin
            m_rd++;
            tick();
            check_model("drain");
        end
        winc = 1'b1;
        for (int i = 0; i < 40; i++) begin
            m_rd = m_wr - 2;
            tick();
            check_model("wrap");
            check("wrap_level", 32'(wlevel), 3);
            check("wrap_nofull", 32'(wfull), 0);
        end

        // Programmable threshold, default fallback, out-of-range threshold.
        wafull_thr = 5;
        tick();
        check("thr5_lvl4", 32'(walmost_full), 0);
        tick();
        check("thr5_lvl5", 32'(walmost_full), 1);
        check_model("thr5");
        wafull_thr = 0; winc = 1'b0;
        tick();
        check("thr_default", 32'(walmost_full), 0);
        wafull_thr = 17; winc = 1'b1;
        while (m_level < DEPTH) begin
            tick();
            check_model("thr17_fill");
        end
        check("thr17_afull", 32'(walmost_full), 0);
        check("thr17_full", 32'(wfull), 1);
        wafull_thr = 0;

        // Reset in the middle of operation, read side reset alongside.
        wrst_n = 1'b0; winc = 1'b0; m_rd = 0;
        tick();
        wrst_n = 1'b1; winc = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        check("mid_level9", 32'(wlevel), 9);
        wrst_n = 1'b0;
        tick();
        check_model("mid_reset");
        check("mid_reset_level", 32'(wlevel), 0);
        wrst_n = 1'b1;
        check("restart_waddr0", 32'(waddr), 0);
        tick();
        check("restart_level1", 32'(wlevel), 1);
        check_model("restart");

        // Random traffic with a reader that never passes the writer.
        for (int i = 0; i < 600; i++) begin
            winc       = ($urandom_range(0, 3) != 0);
            wovf_clr   = ($urandom_range(0, 7) == 0);
            wafull_thr = W'($urandom_range(0, 17));
            if (m_rd < m_wr && $urandom_range(0, 1) == 1) m_rd++;
            tick();
            check_model("random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
